// File: rtl/maze_dfs_explorer.sv
// maze_dfs_explorer
//   Depth-first search over a 16x16 bit map held in an external maze memory
//   (0 = open, 1 = wall). Each visited cell is marked by writing 1. A stack
//   of 2-bit move directions supports backtracking. After the search ends,
//   the solved path is read back one move at a time through path_idx/path_dir.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               1-cycle pulse, honoured only in IDLE, DONE or FAIL
//   mem_x, mem_y        registered cell address to the maze memory
//   mem_rd, mem_wr      1-cycle strobes, never asserted together
//   mem_din             write data (visited mark, always 1 once out of reset)
//   mem_dout            read data, valid the cycle after mem_rd
//   busy, done, fail    search status; done/fail are held until the next start
//   path_len            moves on the path (stack count)
//   path_idx, path_dir  path readout; 0=N(x-1) 1=E(y+1) 2=S(x+1) 3=W(y-1)
module maze_dfs_explorer #(
  parameter logic [3:0]  START_X = 4'd0,
  parameter logic [3:0]  START_Y = 4'd0,
  parameter logic [3:0]  GOAL_X  = 4'd15,
  parameter logic [3:0]  GOAL_Y  = 4'd15,
  parameter int unsigned DEPTH   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  input  logic       mem_dout,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [8:0] path_len,
  input  logic [7:0] path_idx,
  output logic [1:0] path_dir
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK0,
    S_CHK0E,
    S_MARK,
    S_PROBE,
    S_EVAL,
    S_NEXT,
    S_POP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t     state;
  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic [1:0] dir;
  logic [8:0] count;
  logic [1:0] stack [DEPTH];

  // True when the neighbour of (x,y) in direction d lies on the map.
  function automatic logic nbr_ok(input logic [3:0] x, input logic [3:0] y,
                                  input logic [1:0] d);
    logic ok;
    case (d)
      2'd0:    ok = (x != 4'd0);
      2'd1:    ok = (y != 4'd15);
      2'd2:    ok = (x != 4'd15);
      default: ok = (y != 4'd0);
    endcase
    return ok;
  endfunction

  // Neighbour coordinates {x, y}; only meaningful when nbr_ok holds.
  function automatic logic [7:0] step(input logic [3:0] x, input logic [3:0] y,
                                      input logic [1:0] d);
    logic [7:0] r;
    case (d)
      2'd0:    r = {x - 4'd1, y};
      2'd1:    r = {x, y + 4'd1};
      2'd2:    r = {x + 4'd1, y};
      default: r = {x, y - 4'd1};
    endcase
    return r;
  endfunction

  logic          at_goal;
  logic          first_ok;
  logic [7:0]    first_xy;
  logic          probe_ok;
  logic [7:0]    probe_xy;
  logic [1:0]    next_dir;
  logic          next_ok;
  logic [7:0]    next_xy;
  logic [AW-1:0] top_idx;
  logic [1:0]    top_dir;
  logic [7:0]    back_xy;
  logic          stack_full;
  logic          push_en;

  always_comb begin
    at_goal    = (cur_x == GOAL_X) && (cur_y == GOAL_Y);
    first_ok   = nbr_ok(cur_x, cur_y, 2'd0);
    first_xy   = step(cur_x, cur_y, 2'd0);
    probe_ok   = nbr_ok(cur_x, cur_y, dir);
    probe_xy   = step(cur_x, cur_y, dir);
    next_dir   = dir + 2'd1;
    next_ok    = nbr_ok(cur_x, cur_y, next_dir);
    next_xy    = step(cur_x, cur_y, next_dir);
    top_idx    = AW'(count - 9'd1);
    top_dir    = stack[top_idx];
    // Stepping back reverses the popped move: opposite direction is d ^ 2.
    back_xy    = step(cur_x, cur_y, top_dir ^ 2'd2);
    stack_full = (count == 9'(DEPTH));
    push_en    = (state == S_EVAL) && !mem_dout && !stack_full;
  end

  assign path_len = count;
  assign path_dir = stack[AW'(path_idx)];

  // Stack storage has no reset: contents survive DONE/FAIL for readout.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack[AW'(count)] <= dir;
    end
  end

  // The read strobe and address for a probe are issued on the transition
  // into PROBE, so the data is back from memory while in EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cur_x   <= START_X;
      cur_y   <= START_Y;
      dir     <= '0;
      count   <= '0;
      mem_x   <= '0;
      mem_y   <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_din <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      mem_din <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            done   <= 1'b0;
            fail   <= 1'b0;
            busy   <= 1'b1;
            count  <= '0;
            dir    <= '0;
            cur_x  <= START_X;
            cur_y  <= START_Y;
            mem_x  <= START_X;
            mem_y  <= START_Y;
            mem_rd <= 1'b1;
            state  <= S_CHK0;
          end
        end

        S_CHK0: begin
          mem_rd <= 1'b0;
          state  <= S_CHK0E;
        end

        S_CHK0E: begin
          if (mem_dout) begin
            busy  <= 1'b0;
            fail  <= 1'b1;
            state <= S_FAIL;
          end else begin
            mem_wr <= 1'b1;
            state  <= S_MARK;
          end
        end

        S_MARK: begin
          mem_wr <= 1'b0;
          if (at_goal) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            dir <= 2'd0;
            if (first_ok) begin
              mem_rd <= 1'b1;
              {mem_x, mem_y} <= first_xy;
            end
            state <= S_PROBE;
          end
        end

        S_PROBE: begin
          mem_rd <= 1'b0;
          state  <= probe_ok ? S_EVAL : S_NEXT;
        end

        S_EVAL: begin
          if (!mem_dout) begin
            if (stack_full) begin
              busy  <= 1'b0;
              fail  <= 1'b1;
              state <= S_FAIL;
            end else begin
              count          <= count + 9'd1;
              {cur_x, cur_y} <= probe_xy;
              {mem_x, mem_y} <= probe_xy;
              mem_wr         <= 1'b1;
              state          <= S_MARK;
            end
          end else begin
            state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (dir != 2'd3) begin
            dir <= next_dir;
            if (next_ok) begin
              mem_rd <= 1'b1;
              {mem_x, mem_y} <= next_xy;
            end
            state <= S_PROBE;
          end else begin
            state <= S_POP;
          end
        end

        S_POP: begin
          if (count == '0) begin
            busy  <= 1'b0;
            fail  <= 1'b1;
            state <= S_FAIL;
          end else begin
            count          <= count - 9'd1;
            {cur_x, cur_y} <= back_xy;
            dir            <= top_dir;
            state          <= S_NEXT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_dfs_explorer.sv
module tb_maze_dfs_explorer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mem_x;
  logic [3:0] mem_y;
  logic       mem_rd;
  logic       mem_wr;
  logic       mem_din;
  logic       mem_dout = 1'b0;
  logic       busy;
  logic       done;
  logic       fail;
  logic [8:0] path_len;
  logic [7:0] path_idx = '0;
  logic [1:0] path_dir;

  always #5 clk = ~clk;

  maze_dfs_explorer #(
    .START_X(4'd0),
    .START_Y(4'd0),
    .GOAL_X (4'd15),
    .GOAL_Y (4'd15),
    .DEPTH  (256)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mem_x   (mem_x),
    .mem_y   (mem_y),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .mem_din (mem_din),
    .mem_dout(mem_dout),
    .busy    (busy),
    .done    (done),
    .fail    (fail),
    .path_len(path_len),
    .path_idx(path_idx),
    .path_dir(path_dir)
  );

  typedef struct packed {
    logic         done;
    logic         fail;
    logic [8:0]   len;
    logic [15:0]  nwr;
    logic [127:0] dirs;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   issued   = 0;
  int   results  = 0;

  // ---------------- maze memory model ----------------
  logic maze     [16][16];
  logic wr_seen  [16][16];
  int   wr_total = 0;
  logic dbl_wr   = 1'b0;
  logic clash    = 1'b0;
  logic bad_din  = 1'b0;
  int   map_id   = 0;
  logic load_req = 1'b0;

  function automatic logic map_cell(input int id, input int x, input int y);
    case (id)
      1:       return !(x == 0 || y == 15);
      2:       return 1'b1;
      3:       return !(x == 0 && y == 0);
      4:       return !((x == 0 && y <= 3) || y == 0 || x == 15);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          maze[i][j]    <= map_cell(map_id, i, j);
          wr_seen[i][j] <= 1'b0;
        end
      end
      wr_total <= 0;
      dbl_wr   <= 1'b0;
      clash    <= 1'b0;
      bad_din  <= 1'b0;
    end else begin
      if (mem_rd) mem_dout <= maze[mem_x][mem_y];
      if (mem_wr) begin
        maze[mem_x][mem_y]    <= mem_din;
        wr_seen[mem_x][mem_y] <= 1'b1;
        if (wr_seen[mem_x][mem_y]) dbl_wr <= 1'b1;
        if (!mem_din) bad_din <= 1'b1;
        wr_total <= wr_total + 1;
      end
      if (mem_rd && mem_wr) clash <= 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic f, input int len,
                              input int nwr, input logic [1:0] d1,
                              input logic [1:0] d2);
    exp_t e;
    e      = '0;
    e.done = d;
    e.fail = f;
    e.len  = 9'(len);
    e.nwr  = 16'(nwr);
    for (int i = 0; i < len; i++) e.dirs[2*i +: 2] = (i < 15) ? d1 : d2;
    return e;
  endfunction

  task automatic issue(input exp_t e);
    sb_q.push_back(e);
    issued++;
  endtask

  task automatic load_map(input int id);
    @(negedge clk);
    map_id   = id;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input int budget);
    int n;
    n = 0;
    while (results < issued && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (results < issued) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=%0d expected=%0d", results, issued);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_x"}, mem_x, 0);
    chk({tag, "_mem_y"}, mem_y, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_path_len"}, path_len, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;
  initial begin : monitor
    logic term_q;
    int   mism;
    term_q = 1'b0;
    forever begin
      @(negedge clk);
      if ((done || fail) && !term_q) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result done=%0b fail=%0b", done, fail);
        end else begin
          mon_e = sb_q.pop_front();
          chk("done", done, mon_e.done);
          chk("fail", fail, mon_e.fail);
          chk("busy_at_end", busy, 0);
          chk("path_len", path_len, mon_e.len);
          chk("write_count", wr_total, mon_e.nwr);
          chk("double_write", dbl_wr, 0);
          chk("rd_wr_clash", clash, 0);
          chk("din_not_one", bad_din, 0);
          mism = 0;
          for (int i = 0; i < int'(mon_e.len); i++) begin
            path_idx = 8'(i);
            #1;
            if (path_dir != mon_e.dirs[2*i +: 2]) mism++;
          end
          chk("path_dir_mismatches", mism, 0);
        end
        results++;
      end
      term_q = done || fail;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Straight corridor: E x15 then S x15.
    load_map(1);
    issue(mk(1'b1, 1'b0, 30, 31, 2'd1, 2'd2));
    pulse_start();
    chk("busy_running", busy, 1);
    wait_result(5000);

    // Start cell is a wall: fail within 3 cycles, no writes.
    load_map(2);
    issue(mk(1'b0, 1'b1, 0, 0, 2'd0, 2'd0));
    pulse_start();
    n = 0;
    while (!fail && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("wall_start_fail_latency", fail, 1);
    wait_result(50);

    // Only the start cell open: one write, exhausted search.
    load_map(3);
    issue(mk(1'b0, 1'b1, 0, 1, 2'd0, 2'd0));
    pulse_start();
    wait_result(200);

    // Dead-end branch east of start, true path S x15 then E x15.
    load_map(4);
    issue(mk(1'b1, 1'b0, 30, 34, 2'd2, 2'd1));
    pulse_start();
    wait_result(5000);

    // Extra start while busy is ignored.
    load_map(1);
    issue(mk(1'b1, 1'b0, 30, 31, 2'd1, 2'd2));
    pulse_start();
    repeat (20) @(negedge clk);
    chk("busy_before_extra_start", busy, 1);
    pulse_start();
    wait_result(5000);

    // Fresh search after done.
    load_map(1);
    issue(mk(1'b1, 1'b0, 30, 31, 2'd1, 2'd2));
    pulse_start();
    wait_result(5000);

    // Asynchronous reset mid-search, then reload and rerun.
    load_map(1);
    pulse_start();
    repeat (40) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    load_map(1);
    issue(mk(1'b1, 1'b0, 30, 31, 2'd1, 2'd2));
    pulse_start();
    wait_result(5000);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
